alu_cmd_sequencer: RTL and testbench

- Drives the system ALU from a byte-wide command stream: collects opcode and operands, fires the ALU for one cycle, and captures the 16-bit result on the ALU's OUT_VALID.
- Returns the result as a little-endian byte pair over a valid/ready byte interface toward the TX serializer.
- Sits between the command receive path and the ALU, as the initiator/consumer end of the ALU's Enable/OUT_VALID interface.

---
 rtl/alu_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects a three-byte command frame {sync|fun, A, B}, fires the ALU for
// one cycle, captures its 16-bit result and returns it little-endian over a valid/ready byte
// interface.
// Optional feature: define ALU_SEQ_CHKSUM_EN to append a checksum byte
// (opcode ^ result[7:0] ^ result[15:8]) after the result bytes.
module alu_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter logic [3:0]  SYNC_NIBBLE = 4'hC
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    input  logic [15:0] ALU_OUT,
    input  logic        ALU_OUT_VALID,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic        CMD_ERR
);

    typedef enum logic [2:0] {
        StIdle,
        StGetA,
        StGetB,
        StFire,
        StWait,
        StSendLo,
        StSendHi,
        StSendCs
    } state_e;

    // Last counter value allowed in WAIT; 9 bits so TIMEOUT_CYC up to 255 compares cleanly.
    localparam logic [8:0] TmoLast = 9'(TIMEOUT_CYC - 1);

    state_e      state;
    logic [15:0] result;
    logic [7:0]  tmo_cnt;
    logic        rx_fire;
    logic        bad_opcode;
    logic        tmo_hit;

    // Handshake, opcode validation and timeout detection.
    always_comb begin
        rx_fire    = RX_VALID && RX_READY;
        bad_opcode = (RX_DATA[7:4] != SYNC_NIBBLE) || (RX_DATA[3:0] == 4'hF);
        // Abort on the cycle the counter would step onto TIMEOUT_CYC-1.
        tmo_hit    = ({1'b0, tmo_cnt} + 9'd1) >= TmoLast;
    end

    // Outputs decoded directly from the state register.
    always_comb begin
        RX_READY = (state == StIdle) || (state == StGetA) || (state == StGetB);
        BUSY     = (state != StIdle);
        ALU_EN   = (state == StFire);
        TX_VALID = (state == StSendLo) || (state == StSendHi) || (state == StSendCs);
    end

    // Sequencer FSM with its registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= StIdle;
            ALU_A   <= 8'h00;
            ALU_B   <= 8'h00;
            ALU_FUN <= 4'h0;
            result  <= 16'h0000;
            TX_DATA <= 8'h00;
            tmo_cnt <= 8'h00;
            CMD_ERR <= 1'b0;
        end else begin
            CMD_ERR <= 1'b0;
            case (state)
                StIdle: begin
                    if (rx_fire) begin
                        if (bad_opcode) begin
                            CMD_ERR <= 1'b1;
                        end else begin
                            ALU_FUN <= RX_DATA[3:0];
                            state   <= StGetA;
                        end
                    end
                end
                StGetA: begin
                    if (rx_fire) begin
                        ALU_A <= RX_DATA;
                        state <= StGetB;
                    end
                end
                StGetB: begin
                    if (rx_fire) begin
                        ALU_B <= RX_DATA;
                        state <= StFire;
                    end
                end
                StFire: begin
                    // Any OUT_VALID seen here belongs to a previous operation and is ignored.
                    tmo_cnt <= 8'h00;
                    state   <= StWait;
                end
                StWait: begin
                    if (ALU_OUT_VALID) begin
                        result  <= ALU_OUT;
                        TX_DATA <= ALU_OUT[7:0];
                        state   <= StSendLo;
                    end else if (tmo_hit) begin
                        CMD_ERR <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                StSendLo: begin
                    if (TX_READY) begin
                        TX_DATA <= result[15:8];
                        state   <= StSendHi;
                    end
                end
                StSendHi: begin
                    if (TX_READY) begin
`ifdef ALU_SEQ_CHKSUM_EN
                        TX_DATA <= {SYNC_NIBBLE, ALU_FUN} ^ result[7:0] ^ result[15:8];
                        state   <= StSendCs;
`else
                        state   <= StIdle;
`endif
                    end
                end
                StSendCs: begin
                    // Only reachable with the checksum feature; otherwise falls straight back.
                    if (TX_READY) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: registered ALU model, TX scoreboard queue, directed frames.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VALID = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic        CMD_ERR;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int en_cyc = 0;
    int err_cyc = 0;
    logic       alu_mute = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;

    alu_cmd_sequencer dut (
        .clk          (clk),
        .RST          (RST),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_READY     (RX_READY),
        .ALU_A        (ALU_A),
        .ALU_B        (ALU_B),
        .ALU_FUN      (ALU_FUN),
        .ALU_EN       (ALU_EN),
        .ALU_OUT      (ALU_OUT),
        .ALU_OUT_VALID(ALU_OUT_VALID),
        .TX_DATA      (TX_DATA),
        .TX_VALID     (TX_VALID),
        .TX_READY     (TX_READY),
        .BUSY         (BUSY),
        .CMD_ERR      (CMD_ERR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Registered ALU: result and OUT_VALID appear the cycle after Enable.
    always @(posedge clk) begin
        ALU_OUT_VALID <= ALU_EN && !alu_mute;
        if (ALU_EN) begin
            case (ALU_FUN)
                4'h0:    ALU_OUT <= 16'(ALU_A) + 16'(ALU_B);
                4'h1:    ALU_OUT <= 16'(ALU_A) - 16'(ALU_B);
                4'h2:    ALU_OUT <= 16'(ALU_A) * 16'(ALU_B);
                default: ALU_OUT <= {8'h00, ALU_A & ALU_B};
            endcase
        end
    end

    // Monitor: pulse counters and TX scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!RST) begin
            if (ALU_EN) begin
                en_cnt++;
                en_cyc = cyc;
            end
            if (CMD_ERR) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (TX_VALID && TX_READY) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_unexpected got=%0h expected=none", TX_DATA);
                end
                if (exp_q.size() != 0) begin
                    exp_byte = exp_q.pop_front();
                    checks++;
                    assert (TX_DATA === exp_byte) else begin
                        errors++;
                        $error("FAIL tx_byte got=%0h expected=%0h", TX_DATA, exp_byte);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!RX_READY && n < 100);
        chk("rx_accept", 32'(RX_READY), 32'd1);
        @(posedge clk);
        #1;
        RX_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(op);
        send_byte(a);
        send_byte(b);
    endtask

    // Wait for the scoreboard to empty and the sequencer to return to idle.
    task automatic drain(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || BUSY) && n < 200);
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!TX_VALID && n < 100);
        chk("tx_valid_seen", 32'(TX_VALID), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int r0;
        int n;
        RST      = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_READY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
        chk("rst_cmd_err", 32'(CMD_ERR), 32'd0);
        chk("rst_alu_en", 32'(ALU_EN), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_alu_a", 32'(ALU_A), 32'd0);
        chk("rst_alu_b", 32'(ALU_B), 32'd0);
        chk("rst_alu_fun", 32'(ALU_FUN), 32'd0);
        RST = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rx_ready", 32'(RX_READY), 32'd1);

        // ADD 0x30 + 0x12 with TX always ready.
        e0 = en_cnt;
        r0 = err_cnt;
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h00);
`ifdef ALU_SEQ_CHKSUM_EN
        exp_q.push_back(8'h82);
`endif
        send_frame(8'hC0, 8'h30, 8'h12);
        drain("add_drain");
        chk("add_en_pulses", 32'(en_cnt - e0), 32'd1);
        chk("add_alu_a", 32'(ALU_A), 32'h30);
        chk("add_alu_b", 32'(ALU_B), 32'h12);
        chk("add_alu_fun", 32'(ALU_FUN), 32'h0);
        chk("add_no_err", 32'(err_cnt - r0), 32'd0);

        // MUL 0xFF * 0xFF with TX stalled for three cycles.
        TX_READY = 1'b0;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
`ifdef ALU_SEQ_CHKSUM_EN
        exp_q.push_back(8'h3D);
`endif
        send_frame(8'hC2, 8'hFF, 8'hFF);
        wait_tx_valid();
        chk("mul_hold0", 32'(TX_DATA), 32'h01);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("mul_hold_valid", 32'(TX_VALID), 32'd1);
            chk("mul_hold_data", 32'(TX_DATA), 32'h01);
        end
        @(posedge clk);
        #1;
        TX_READY = 1'b1;
        drain("mul_drain");

        // Bad sync nibble, then reserved function code.
        e0 = en_cnt;
        r0 = err_cnt;
        send_byte(8'h52);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bad_sync_err", 32'(err_cnt - r0), 32'd1);
        chk("bad_sync_idle", 32'(BUSY), 32'd0);
        send_byte(8'hCF);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bad_fun_err", 32'(err_cnt - r0), 32'd2);
        chk("bad_fun_idle", 32'(BUSY), 32'd0);
        chk("bad_no_en", 32'(en_cnt - e0), 32'd0);

        // ALU never answers: timeout abort.
        alu_mute = 1'b1;
        r0 = err_cnt;
        send_frame(8'hC0, 8'h01, 8'h01);
        n = 0;
        while (err_cnt == r0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_err", 32'(err_cnt - r0), 32'd1);
        chk("tmo_delay", 32'(err_cyc - en_cyc), 32'd15);
        chk("tmo_idle", 32'(BUSY), 32'd0);
        chk("tmo_no_tx", 32'(exp_q.size()), 32'd0);
        alu_mute = 1'b0;
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'h00);
`ifdef ALU_SEQ_CHKSUM_EN
        exp_q.push_back(8'hCB);
`endif
        send_frame(8'hC0, 8'h05, 8'h06);
        drain("post_tmo_drain");

        // Reset while the high byte is pending.
        r0 = err_cnt;
        TX_READY = 1'b0;
        exp_q.push_back(8'h03);
        send_frame(8'hC0, 8'h01, 8'h02);
        wait_tx_valid();
        @(posedge clk);
        #1;
        TX_READY = 1'b1;
        @(posedge clk);
        #1;
        TX_READY = 1'b0;
        chk("pre_rst_valid", 32'(TX_VALID), 32'd1);
        chk("pre_rst_hi", 32'(TX_DATA), 32'h00);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", 32'(TX_VALID), 32'd0);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        @(posedge clk);
        #1;
        RST = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_no_err", 32'(err_cnt - r0), 32'd0);
        chk("rst_q_empty", 32'(exp_q.size()), 32'd0);
        TX_READY = 1'b1;
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h00);
`ifdef ALU_SEQ_CHKSUM_EN
        exp_q.push_back(8'hC4);
`endif
        send_frame(8'hC1, 8'h09, 8'h04);
        drain("sub_drain");
        chk("final_no_err", 32'(err_cnt - r0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
